// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame states, data width and bit-timing derivation.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    // Rounded clocks per bit, so TX and RX agree on timing for any clock/baud pair.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the async input through two flops; stage 1 absorbs metastability.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
module uart_rx #(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_bit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    import uart_rx_pkg::*;

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic                     rx_s;
    uart_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic                     deliver_q, deliver_d;
    logic                     ferr_q, ferr_d;
    logic [DATA_BITS-1:0]     data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ovr_q, ovr_d;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (rx_bit),
        .q_o   (rx_s)
    );

    // Frame state, timing counters and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            deliver_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic: counter restarts at every sample point so timing never drifts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_LAST) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register and overrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // A delivery into a register being drained the same cycle replaces the byte without loss.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (deliver_q) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table of frames plus hand-written corner sequences.
module tb_uart_rx;

    localparam int unsigned CPB = 104;  // (12e6 + 57600) / 115200

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_bit;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    uart_rx #(
        .CLK_HZ(12000000),
        .BAUD  (115200)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_bit   (rx_bit),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record accepted bytes and count pulses.
    logic [7:0]  obs_mem [0:63];
    int          obs_n = 0;
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    int          rise_cnt = 0;
    int unsigned last_rise_cyc = 0;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            obs_mem[obs_n[5:0]] <= rx_data;
            obs_n <= obs_n + 1;
        end
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_cnt      <= rise_cnt + 1;
            last_rise_cyc <= cyc;
        end
        prev_valid <= rx_valid;
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          obs_rd = 0;
    int unsigned start_cyc = 0;
    logic [7:0]  exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every byte the monitor has seen against the scoreboard.
    task automatic drain();
        while (obs_rd < obs_n) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got %02h expected none", obs_mem[obs_rd[5:0]]);
            end else begin
                check("rx_data", 32'(obs_mem[obs_rd[5:0]]), 32'(exp_q.pop_front()));
            end
            obs_rd++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic end_val);
        @(posedge clk);
        #1 rx_bit = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_bit = d[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx_bit = stop_val;
        repeat (CPB) @(posedge clk);
        #1 rx_bit = end_val;
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        logic       exp_byte;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int r0, f0, o0, lat, lat1;

        vecs[0] = '{8'h41, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h7E, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'hA5, 1'b1, 1'b1, 1'b0};

        reset    = 1'b1;
        rx_bit   = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data",   32'(rx_data),   32'h00);
        check("reset_rx_valid",  32'(rx_valid),  32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun",   32'(overrun),   32'd0);
        check("reset_rx_busy",   32'(rx_busy),   32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);

        // Table of single frames with the consumer always ready.
        for (int v = 0; v < 7; v++) begin
            r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
            if (vecs[v].exp_byte) exp_q.push_back(vecs[v].data);
            send_frame(vecs[v].data, vecs[v].stop_val, 1'b1);
            repeat (20) @(posedge clk);
            #1;
            check("vec_valid_count", 32'(rise_cnt - r0), 32'(vecs[v].exp_byte));
            check("vec_frame_err",   32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
            check("vec_overrun",     32'(ovr_cnt - o0),  32'd0);
            if (v == 0) begin
                lat = int'(last_rise_cyc - start_cyc);
                check("latency_991pm1", (lat >= 990 && lat <= 992) ? 32'd991 : 32'(lat), 32'd991);
            end
            drain();
        end

        // Short glitch on an idle line is rejected as a false start.
        r0 = rise_cnt; f0 = ferr_cnt;
        @(posedge clk);
        #1 rx_bit = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx_bit = 1'b1;
        check("glitch_busy_start", 32'(rx_busy), 32'd1);
        repeat (36) @(posedge clk);
        #1 check("glitch_idle_by_56", 32'(rx_busy), 32'd0);
        repeat (200) @(posedge clk);
        check("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);
        check("glitch_no_ferr",  32'(ferr_cnt - f0), 32'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1 check("glitch_then_byte", 32'(rise_cnt - r0), 32'd1);
        drain();

        // Bad stop bit followed by a long break: one frame error only.
        r0 = rise_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (2000) @(posedge clk);
        #1;
        check("break_ferr_once", 32'(ferr_cnt - f0), 32'd1);
        check("break_no_valid",  32'(rise_cnt - r0), 32'd0);
        check("break_busy",      32'(rx_busy),       32'd1);
        rx_bit = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("break_exit_idle", 32'(rx_busy), 32'd0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1 check("break_then_byte", 32'(rise_cnt - r0), 32'd1);
        drain();

        // Overrun: second byte arrives while the first is still held.
        rx_ready = 1'b0;
        r0 = rise_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("ovr_pulse_count", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_valid_held",  32'(rx_valid),     32'd1);
        check("ovr_data_kept",   32'(rx_data),      32'hA5);
        pulse_ready();
        @(posedge clk);
        #1 check("ovr_consumed", 32'(rx_valid), 32'd0);
        drain();

        // Consumer drains in exactly the delivery cycle of the next byte.
        o0 = ovr_cnt;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b1);
        lat1 = int'(last_rise_cyc - start_cyc);
        repeat (20) @(posedge clk);
        #1 check("hold_01_valid", 32'(rx_valid), 32'd1);
        exp_q.push_back(8'h02);
        fork
            send_frame(8'h02, 1'b1, 1'b1);
            begin
                @(posedge clk);
                repeat (lat1 - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        #1;
        check("swap_valid",   32'(rx_valid),     32'd1);
        check("swap_data",    32'(rx_data),      32'h02);
        check("swap_overrun", 32'(ovr_cnt - o0), 32'd0);
        pulse_ready();
        repeat (2) @(posedge clk);
        drain();

        // Reset in the middle of a frame while a byte is held.
        send_frame(8'h33, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1 check("pre_reset_held", 32'(rx_valid), 32'd1);
        fork
            send_frame(8'hF0, 1'b1, 1'b1);
            begin
                @(posedge clk);
                repeat (560) @(posedge clk);
                #1 reset = 1'b1;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("midrst_rx_valid",  32'(rx_valid),  32'd0);
                check("midrst_rx_data",   32'(rx_data),   32'h00);
                check("midrst_rx_busy",   32'(rx_busy),   32'd0);
                check("midrst_frame_err", 32'(frame_err), 32'd0);
                check("midrst_overrun",   32'(overrun),   32'd0);
                @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        r0 = rise_cnt; f0 = ferr_cnt;
        rx_ready = 1'b1;
        repeat (50) @(posedge clk);
        #1 check("post_reset_quiet", 32'(rise_cnt - r0), 32'd0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_one_byte", 32'(rise_cnt - r0), 32'd1);
        check("post_reset_no_ferr",  32'(ferr_cnt - f0), 32'd0);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
